// File: rtl/exec_pkg.sv
// rtl/exec_pkg.sv - shared opcode, ALU function and control bundle definitions
package exec_pkg;

  localparam int DATA_W = 8;

  // Opcodes carried in instruction bits [31:24]
  localparam logic [7:0] OP_LOADI = 8'h00;
  localparam logic [7:0] OP_MOV   = 8'h01;
  localparam logic [7:0] OP_ADD   = 8'h02;
  localparam logic [7:0] OP_SUB   = 8'h03;
  localparam logic [7:0] OP_AND   = 8'h04;
  localparam logic [7:0] OP_OR    = 8'h05;
  localparam logic [7:0] OP_J     = 8'h06;
  localparam logic [7:0] OP_BEQ   = 8'h07;

  // ALU function codes; 100-111 are reserved and produce 0x00
  localparam logic [2:0] ALU_FWD = 3'b000;
  localparam logic [2:0] ALU_ADD = 3'b001;
  localparam logic [2:0] ALU_AND = 3'b010;
  localparam logic [2:0] ALU_OR  = 3'b011;

  // Decoded control bundle for one instruction
  typedef struct packed {
    logic       neg;
    logic       immsel;
    logic [2:0] aluop;
    logic       we;
    logic       br;
    logic       j;
  } ctrl_t;

  // Opcode decoder; anything outside loadi..beq becomes a no-op that forwards the immediate
  function automatic ctrl_t decode(input logic [7:0] opcode);
    ctrl_t c;
    c = '{neg: 1'b0, immsel: 1'b0, aluop: ALU_FWD, we: 1'b0, br: 1'b0, j: 1'b0};
    case (opcode)
      OP_LOADI: begin c.immsel = 1'b1; c.we = 1'b1; end
      OP_MOV:   begin c.we = 1'b1; end
      OP_ADD:   begin c.aluop = ALU_ADD; c.we = 1'b1; end
      OP_SUB:   begin c.neg = 1'b1; c.aluop = ALU_ADD; c.we = 1'b1; end
      OP_AND:   begin c.aluop = ALU_AND; c.we = 1'b1; end
      OP_OR:    begin c.aluop = ALU_OR; c.we = 1'b1; end
      OP_J:     begin c.j = 1'b1; end
      OP_BEQ:   begin c.neg = 1'b1; c.aluop = ALU_ADD; c.br = 1'b1; end
      default:  begin c.immsel = 1'b1; end
    endcase
    return c;
  endfunction

endpackage

// File: rtl/exec_alu.sv
// rtl/exec_alu.sv - combinational 8-bit ALU with zero detect
module exec_alu
  import exec_pkg::*;
#(
  parameter int DATA_W = 8
) (
  input  logic [DATA_W-1:0] a,
  input  logic [DATA_W-1:0] b,
  input  logic [2:0]        aluop,
  output logic [DATA_W-1:0] result,
  output logic              zero
);

  // Function select; addition wraps and the carry is dropped
  always_comb begin
    result = '0;
    case (aluop)
      ALU_FWD: result = b;
      ALU_ADD: result = a + b;
      ALU_AND: result = a & b;
      ALU_OR:  result = a | b;
      default: result = '0;
    endcase
  end

  assign zero = (result == '0);

endmodule

// File: rtl/exec_ctrl_unit.sv
// rtl/exec_ctrl_unit.sv - decode/execute stage with registered ALU and PC-select outputs
module exec_ctrl_unit
  import exec_pkg::*;
#(
  parameter int DATA_W = 8
) (
  input  logic              CLK,
  input  logic              RESET,
  input  logic [7:0]        OPCODE,
  input  logic [DATA_W-1:0] DATA1,
  input  logic [DATA_W-1:0] DATA2,
  input  logic [DATA_W-1:0] IMMEDIATE,
  output logic [DATA_W-1:0] RESULT,
  output logic              ZERO,
  output logic              WRITEENABLE,
  output logic              JUMP,
  output logic              BRANCH,
  output logic              PCSEL,
  output logic [2:0]        ALUOP
);

  ctrl_t             ctrl;
  logic [DATA_W-1:0] negv;
  logic [DATA_W-1:0] mux1;
  logic [DATA_W-1:0] op2;
  logic [DATA_W-1:0] alu_result;
  logic              alu_zero;

  // Decode, two's-complement negate and operand-2 select
  always_comb begin
    ctrl = decode(OPCODE);
    negv = ~DATA2 + {{(DATA_W-1){1'b0}}, 1'b1};
    mux1 = ctrl.neg ? negv : DATA2;
    op2  = ctrl.immsel ? IMMEDIATE : mux1;
  end

  exec_alu #(
    .DATA_W (DATA_W)
  ) u_alu (
    .a      (DATA1),
    .b      (op2),
    .aluop  (ctrl.aluop),
    .result (alu_result),
    .zero   (alu_zero)
  );

  // Output register; reset wins over whatever instruction is presented on the same edge
  always_ff @(posedge CLK) begin
    if (RESET) begin
      RESULT      <= '0;
      ZERO        <= 1'b0;
      WRITEENABLE <= 1'b0;
      JUMP        <= 1'b0;
      BRANCH      <= 1'b0;
      PCSEL       <= 1'b0;
      ALUOP       <= ALU_FWD;
    end else begin
      RESULT      <= alu_result;
      ZERO        <= alu_zero;
      WRITEENABLE <= ctrl.we;
      JUMP        <= ctrl.j;
      BRANCH      <= ctrl.br;
      PCSEL       <= ctrl.j | (ctrl.br & alu_zero);
      ALUOP       <= ctrl.aluop;
    end
  end

endmodule

// File: tb/tb_exec_ctrl_unit.sv
// tb/tb_exec_ctrl_unit.sv - scoreboard bench for exec_ctrl_unit with directed and random instructions
module tb_exec_ctrl_unit;

  logic       CLK = 1'b0;
  logic       RESET = 1'b1;
  logic [7:0] OPCODE = 8'h00;
  logic [7:0] DATA1 = 8'h00;
  logic [7:0] DATA2 = 8'h00;
  logic [7:0] IMMEDIATE = 8'h00;
  logic [7:0] RESULT;
  logic       ZERO;
  logic       WRITEENABLE;
  logic       JUMP;
  logic       BRANCH;
  logic       PCSEL;
  logic [2:0] ALUOP;

  typedef struct packed {
    logic [7:0] result;
    logic       zero;
    logic       we;
    logic       j;
    logic       br;
    logic       pcsel;
    logic [2:0] aluop;
  } exp_t;

  exp_t exp_q[$];
  int   n_checks = 0;
  int   n_pass = 0;

  exec_ctrl_unit #(.DATA_W(8)) dut (
    .CLK         (CLK),
    .RESET       (RESET),
    .OPCODE      (OPCODE),
    .DATA1       (DATA1),
    .DATA2       (DATA2),
    .IMMEDIATE   (IMMEDIATE),
    .RESULT      (RESULT),
    .ZERO        (ZERO),
    .WRITEENABLE (WRITEENABLE),
    .JUMP        (JUMP),
    .BRANCH      (BRANCH),
    .PCSEL       (PCSEL),
    .ALUOP       (ALUOP)
  );

  always #5 CLK = ~CLK;

  // Reference: instruction semantics in plain integer arithmetic
  function automatic exp_t model(input logic rst, input logic [7:0] op,
                                 input logic [7:0] d1, input logic [7:0] d2,
                                 input logic [7:0] imm);
    exp_t e;
    int   r;
    e = '0;
    r = 0;
    if (rst) return e;
    case (op)
      8'h00: begin r = int'(imm); e.we = 1'b1; end
      8'h01: begin r = int'(d2); e.we = 1'b1; end
      8'h02: begin r = int'(d1) + int'(d2); e.aluop = 3'd1; e.we = 1'b1; end
      8'h03: begin r = int'(d1) + 256 - int'(d2); e.aluop = 3'd1; e.we = 1'b1; end
      8'h04: begin r = int'(d1 & d2); e.aluop = 3'd2; e.we = 1'b1; end
      8'h05: begin r = int'(d1 | d2); e.aluop = 3'd3; e.we = 1'b1; end
      8'h06: begin r = int'(d2); e.j = 1'b1; end
      8'h07: begin r = int'(d1) + 256 - int'(d2); e.aluop = 3'd1; e.br = 1'b1; end
      default: r = int'(imm);
    endcase
    e.result = 8'(r % 256);
    e.zero   = ((r % 256) == 0);
    e.pcsel  = e.j || (e.br && (d1 == d2));
    return e;
  endfunction

  task automatic check(input string name, input int act, input int expv);
    n_checks++;
    if (act == expv) n_pass++;
    else $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, expv, $time);
  endtask

  // Apply one instruction between edges and record its expected registered outcome
  task automatic issue(input logic rst, input logic [7:0] op, input logic [7:0] d1,
                       input logic [7:0] d2, input logic [7:0] imm);
    @(negedge CLK);
    RESET     = rst;
    OPCODE    = op;
    DATA1     = d1;
    DATA2     = d2;
    IMMEDIATE = imm;
    exp_q.push_back(model(rst, op, d1, d2, imm));
  endtask

  // Monitor: outputs are valid every cycle, one expectation consumed per edge
  initial begin
    exp_t e;
    forever begin
      @(posedge CLK);
      #1;
      if (exp_q.size() > 0) begin
        e = exp_q.pop_front();
        check("RESULT",      int'(RESULT),      int'(e.result));
        check("ZERO",        int'(ZERO),        int'(e.zero));
        check("WRITEENABLE", int'(WRITEENABLE), int'(e.we));
        check("JUMP",        int'(JUMP),        int'(e.j));
        check("BRANCH",      int'(BRANCH),      int'(e.br));
        check("PCSEL",       int'(PCSEL),       int'(e.pcsel));
        check("ALUOP",       int'(ALUOP),       int'(e.aluop));
      end
    end
  end

  initial begin
    int          wait_cycles;
    logic [7:0]  op;
    logic [7:0]  d1;
    logic [7:0]  d2;
    // reset held with an add presented, then released
    issue(1'b1, 8'h02, 8'h05, 8'h03, 8'h00);
    issue(1'b1, 8'h02, 8'h05, 8'h03, 8'h00);
    issue(1'b0, 8'h02, 8'h05, 8'h03, 8'h00);
    // sub to zero and negative
    issue(1'b0, 8'h03, 8'h05, 8'h05, 8'h00);
    issue(1'b0, 8'h03, 8'h02, 8'h05, 8'h00);
    // beq taken / not taken
    issue(1'b0, 8'h07, 8'h2A, 8'h2A, 8'h00);
    issue(1'b0, 8'h07, 8'h2A, 8'h2B, 8'h00);
    // loadi, mov, and, or
    issue(1'b0, 8'h00, 8'h00, 8'h11, 8'hAB);
    issue(1'b0, 8'h01, 8'h00, 8'h11, 8'hAB);
    issue(1'b0, 8'h04, 8'hF0, 8'h3C, 8'h00);
    issue(1'b0, 8'h05, 8'hF0, 8'h3C, 8'h00);
    // jump and add wrap
    issue(1'b0, 8'h06, 8'h00, 8'h00, 8'h00);
    issue(1'b0, 8'h02, 8'hFF, 8'h01, 8'h00);
    // complementer corners: 0x80 and 0x00
    issue(1'b0, 8'h03, 8'h80, 8'h80, 8'h00);
    issue(1'b0, 8'h07, 8'h00, 8'h00, 8'h00);
    // undefined opcode, then reset with a jump presented
    issue(1'b0, 8'h9C, 8'h12, 8'h34, 8'h56);
    issue(1'b1, 8'h06, 8'h00, 8'h00, 8'h00);
    issue(1'b0, 8'h9C, 8'h12, 8'h34, 8'h00);
    // random instruction stream with occasional reset
    for (int i = 0; i < 400; i++) begin
      op = ($urandom_range(0, 3) == 0) ? 8'($urandom) : 8'($urandom_range(0, 7));
      d1 = 8'($urandom);
      d2 = ($urandom_range(0, 3) == 0) ? d1 : 8'($urandom);
      issue(($urandom_range(0, 19) == 0), op, d1, d2, 8'($urandom));
    end
    @(negedge CLK);
    RESET = 1'b0;
    wait_cycles = 0;
    while (exp_q.size() > 0 && wait_cycles < 10) begin
      @(negedge CLK);
      wait_cycles++;
    end
    if (exp_q.size() > 0) begin
      n_checks++;
      $display("FAIL drain: %0d expectations left, expected 0", exp_q.size());
    end
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
